// File: rtl/l2_refill_ctrl.sv
// l2_refill_ctrl: schedules DDR read bursts into L2 port B when the L2 has
// room, and gates each returned 128-bit beat in as a port-B write.
module l2_refill_ctrl #(
   parameter int BURST_BEATS = 8,
   parameter int ADDR_W      = 28
) (
   input  logic              clk_166M66,
   input  logic              mcu_sys_rst_n,
   input  logic              i_refill_enable,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_base_load,
   input  logic [11:0]       i_l2_unread_size,
   input  logic              i_l1ddr_rw_confilicts,
   output logic              o_ddr_rd_req,
   output logic [ADDR_W-1:0] o_ddr_rd_addr,
   output logic [7:0]        o_ddr_rd_len,
   input  logic              i_ddr_rd_ack,
   input  logic              i_ddr_rd_valid,
   input  logic              i_ddr_rd_last,
   output logic              o_l2_ddr_operate_enable,
   output logic              o_l2_ddr_rw,
   output logic              o_busy,
   input  logic              i_err_clr,
   output logic              o_proto_err
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DATA,
      SETTLE
   } state_t;

   localparam logic [12:0]       LP_WORDS = 13'(BURST_BEATS * 8);
   localparam logic [7:0]        LP_LEN   = 8'(BURST_BEATS);
   localparam logic [ADDR_W-1:0] LP_STEP  = ADDR_W'(BURST_BEATS);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W-1:0] r_req_addr;
   logic [ADDR_W-1:0] r_pend_addr;
   logic              r_pend;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic              w_room;
   logic              w_start;
   logic              w_beat;
   logic [7:0]        w_cnt_nx;
   logic              w_full;
   logic              w_end;
   logic              w_err_set;
   logic              w_in_data;
   logic              w_busy_ld;

   // 13-bit sum cannot wrap: 4095 + 255*8 fits
   assign w_room    = ({1'b0, i_l2_unread_size} + LP_WORDS) <= 13'd4095;
   assign w_start   = i_refill_enable & w_room
                    & ~i_l1ddr_rw_confilicts & ~i_base_load;
   assign w_in_data = (r_state == DATA);
   assign w_beat    = w_in_data & i_ddr_rd_valid;
   assign w_cnt_nx  = r_cnt + 8'd1;
   assign w_full    = (w_cnt_nx == LP_LEN);
   assign w_end     = w_beat & (i_ddr_rd_last | w_full);
   assign w_err_set = (i_ddr_rd_valid & ~w_in_data)
                    | (w_beat & (i_ddr_rd_last ^ w_full));
   assign w_busy_ld = i_base_load & ((r_state == REQ) | w_in_data);

   always_comb begin
      w_next                  = r_state;
      o_ddr_rd_req            = 1'b0;
      o_l2_ddr_operate_enable = 1'b0;
      o_l2_ddr_rw             = 1'b0;
      o_busy                  = 1'b1;
      unique case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (w_start) w_next = REQ;
         end
         REQ: begin
            o_ddr_rd_req = 1'b1;
            if (i_ddr_rd_ack) w_next = DATA;
         end
         DATA: begin
            o_l2_ddr_operate_enable = i_ddr_rd_valid;
            o_l2_ddr_rw             = 1'b1;
            if (w_end) w_next = SETTLE;
         end
         SETTLE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign o_ddr_rd_addr = r_req_addr;
   assign o_ddr_rd_len  = LP_LEN;
   assign o_proto_err   = r_err;

   always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
      if (!mcu_sys_rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_req_addr  <= '0;
         r_pend_addr <= '0;
         r_pend      <= 1'b0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_err_set) r_err <= 1'b1;
         else if (i_err_clr) r_err <= 1'b0;
         if (w_beat) r_cnt <= w_end ? 8'd0 : w_cnt_nx;
         if (w_busy_ld) begin
            r_pend      <= 1'b1;
            r_pend_addr <= i_base_addr;
         end
         unique case (r_state)
            IDLE: begin
               if (i_base_load) r_ptr <= i_base_addr;
               else if (w_start) r_req_addr <= r_ptr;
            end
            DATA: begin
               if (w_end) r_ptr <= r_ptr + LP_STEP;
            end
            SETTLE: begin
               // a load here is newest, so it beats any older pending one
               if (i_base_load) r_ptr <= i_base_addr;
               else if (r_pend) r_ptr <= r_pend_addr;
               r_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
